aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter ITER_LAT, default 4: clock cycles per iteration through the round element, legal range 1..15.
REQ-002 SHALL have parameter NR, default 10: number of AES rounds (AES-128).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  block request valid.
REQ-006 out_ready_in  output  1  request accepted when in_valid and out_ready_in are both high.
REQ-007 in_inv  input  1  1 = decrypt, 0 = encrypt; sampled on accept.
REQ-008 in_block  input  128  plaintext or ciphertext; sampled on accept.
REQ-009 out_valid  output  1  result valid.
REQ-010 in_out_ready  input  1  result consumed when out_valid and in_out_ready are both high.
REQ-011 out_block  output  128  result.
REQ-012 out_ele_load, out_ele_rk_bypass, out_ele_smc_1_bypass, out_ele_smc_2_bypass, out_ele_inv  output  1 each  round-element control flags.
REQ-013 out_ele_s  output  128  round-element state input (held input block).
REQ-014 in_ele_s  input  128  round-element state output.
REQ-015 out_rk_idx  output  4  round-key index to key store.
REQ-016 out_busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
  - IDLE -> RUN on accept.
  - RUN -> DONE at the end of iteration NR.
  - DONE -> IDLE on result consume.
REQ-018 out_ready_in SHALL be high only in IDLE, so exactly one block is in flight.
REQ-019 On accept, SHALL register in_block into out_ele_s and in_inv into out_ele_inv, and clear iteration counter it (0..NR) and cycle counter cy (0..ITER_LAT-1).
REQ-020 In RUN, each iteration SHALL last exactly ITER_LAT cycles with all flags and out_rk_idx held stable.
  - cy increments every cycle.
  - When cy = ITER_LAT-1, cy wraps to 0 and it increments.
REQ-021 out_rk_idx SHALL equal it when encrypting and NR-it when decrypting.
REQ-022 Iteration 0 flags: load=1, rk_bypass=1, smc_1_bypass=1, smc_2_bypass=1.
REQ-023 Encrypt, it = 1..NR-1: load=0, rk_bypass=1, smc_1_bypass=0, smc_2_bypass=1.
REQ-024 Decrypt, it = 1..NR-1: load=0, rk_bypass=0, smc_1_bypass=0, smc_2_bypass=1 at it=1 and 0 otherwise.
REQ-025 Final iteration it = NR: load=0, rk_bypass=1, smc_1_bypass=1; smc_2_bypass=1 for encrypt, 0 for decrypt.
REQ-026 In IDLE and DONE, all flags SHALL be 0 except load=1 and rk_bypass=1.
REQ-027 On the last cycle of iteration NR, SHALL capture in_ele_s into out_block and assert out_valid the following cycle.
REQ-028 out_valid and out_block SHALL hold steady until consumed; back-pressure of any length causes no change.
REQ-029 On the consume cycle, SHALL drop out_valid and enter IDLE, raising out_ready_in the next cycle; no same-cycle re-accept.
REQ-030 SHALL ignore in_valid while busy; in_inv and in_block changes while busy SHALL have no effect.
REQ-031 Total accept-to-out_valid latency SHALL be (NR+1)*ITER_LAT+1 cycles.

Reset
REQ-032 Asserting rst_n low SHALL immediately force the following, including mid-operation with the block discarded:
  - state to IDLE, it=0, cy=0;
  - out_valid=0, out_block=0, out_ele_s=0, out_ele_inv=0, out_rk_idx=0;
  - flags as in REQ-026; out_ready_in=1, out_busy=0.
REQ-033 First accept SHALL be possible on the first rising edge after deassertion.

Structure
REQ-034 FSM state encoding, NR and the flag-table constants SHALL live in the shared package aes_pkg.
REQ-035 SHALL be a single module with no sub-modules; a flag-decode function in aes_pkg is permitted.

Verification
REQ-036 Encrypt FIPS-197 C.1 (key 000102..0f, pt 00112233..ff) through the real round element and key store, ITER_LAT=4 -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 45.
REQ-037 Decrypt 69c4e0d8..c55a with the same key -> 00112233445566778899aabbccddeeff; out_rk_idx sequence 10,9,...,0.
REQ-038 Hold in_out_ready low for 20 cycles after out_valid -> out_block stable, out_ready_in=0, a new in_valid ignored; accept occurs one cycle after consume.
REQ-039 Assert rst_n low at it=5, cy=2 -> all outputs at reset values asynchronously; next block after reset encrypts correctly.
REQ-040 ITER_LAT=1 and ITER_LAT=15 with back-to-back requests -> latencies of 12 and 166 cycles respectively, flags change only at iteration boundaries.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round-element control flags, MSB first.
    typedef struct packed {
        logic load;
        logic rk_bypass;
        logic smc_1_bypass;
        logic smc_2_bypass;
    } ele_flags_t;

    localparam ele_flags_t FLAGS_IDLE     = 4'b1100;
    localparam ele_flags_t FLAGS_FIRST    = 4'b1111;
    localparam ele_flags_t FLAGS_ENC_MID  = 4'b0101;
    localparam ele_flags_t FLAGS_DEC_MID  = 4'b0000;
    localparam ele_flags_t FLAGS_DEC_MID1 = 4'b0001;
    localparam ele_flags_t FLAGS_ENC_LAST = 4'b0111;
    localparam ele_flags_t FLAGS_DEC_LAST = 4'b0110;

    // Flag set for iteration 'it' of an nr-round operation.
    function automatic ele_flags_t flag_decode(
        input logic [3:0] it,
        input logic [3:0] nr,
        input logic       inv
    );
        ele_flags_t f;
        if (it == 4'd0) begin
            f = FLAGS_FIRST;
        end else if (it == nr) begin
            f = inv ? FLAGS_DEC_LAST : FLAGS_ENC_LAST;
        end else if (inv) begin
            f = (it == 4'd1) ? FLAGS_DEC_MID1 : FLAGS_DEC_MID;
        end else begin
            f = FLAGS_ENC_MID;
        end
        return f;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps an iterative round element through NR+1
// iterations of ITER_LAT cycles each, one block in flight at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a new block; element flags parked at load/rk_bypass
//   RUN     | iterating; it/cy count iterations and cycles within one
//   DONE    | result held on out_block/out_valid until consumed
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int ITER_LAT = 4,
    parameter int NR       = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         out_ready_in,
    input  logic         in_inv,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         in_out_ready,
    output logic [127:0] out_block,
    output logic         out_ele_load,
    output logic         out_ele_rk_bypass,
    output logic         out_ele_smc_1_bypass,
    output logic         out_ele_smc_2_bypass,
    output logic         out_ele_inv,
    output logic [127:0] out_ele_s,
    input  logic [127:0] in_ele_s,
    output logic [3:0]   out_rk_idx,
    output logic         out_busy
);

    localparam logic [3:0] NR_L   = NR[3:0];
    localparam logic [3:0] LAT_M1 = 4'(ITER_LAT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_it;
    logic [3:0]   r_cy;
    logic         r_inv;
    logic [127:0] r_ele_s;
    logic [127:0] r_out_block;
    logic         r_out_valid;
    logic         w_accept;
    logic         w_cy_last;
    logic         w_it_last;
    logic         w_capture;
    logic         w_consume;
    ele_flags_t   w_flags;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_cy_last = (r_cy == LAT_M1);
    assign w_it_last = (r_it == NR_L);
    assign w_capture = (r_state == ST_RUN) && w_cy_last && w_it_last;
    assign w_consume = (r_state == ST_DONE) && in_out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_capture) w_state_nxt = ST_DONE;
            ST_DONE: if (w_consume) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Iteration and cycle counters; it returns to 0 once the last
    // iteration completes so the key index parks at its start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_it <= '0;
            r_cy <= '0;
        end else if (w_accept) begin
            r_it <= '0;
            r_cy <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_cy_last) begin
                r_cy <= '0;
                r_it <= w_it_last ? 4'd0 : r_it + 4'd1;
            end else begin
                r_cy <= r_cy + 4'd1;
            end
        end
    end

    // Block and direction are captured only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ele_s <= '0;
            r_inv   <= 1'b0;
        end else if (w_accept) begin
            r_ele_s <= in_block;
            r_inv   <= in_inv;
        end
    end

    // Result capture on the final cycle; valid held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_block <= '0;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_block <= in_ele_s;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Element flags follow the iteration only while running.
    always_comb begin
        w_flags = FLAGS_IDLE;
        if (r_state == ST_RUN) begin
            w_flags = flag_decode(r_it, NR_L, r_inv);
        end
    end

    assign out_ele_load         = w_flags.load;
    assign out_ele_rk_bypass    = w_flags.rk_bypass;
    assign out_ele_smc_1_bypass = w_flags.smc_1_bypass;
    assign out_ele_smc_2_bypass = w_flags.smc_2_bypass;
    assign out_ele_inv          = (r_state == ST_RUN) && r_inv;
    assign out_ele_s            = r_ele_s;
    assign out_rk_idx           = r_inv ? (NR_L - r_it) : r_it;
    assign out_block            = r_out_block;
    assign out_valid            = r_out_valid;
    assign out_ready_in         = (r_state == ST_IDLE);
    assign out_busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (ITER_LAT 4, 1, 15) with a
// cycle-accurate reference of the controller and a result scoreboard.
// The round element is stood in for by in_ele_s = out_ele_s ^ cycle, so
// the captured result also pins down the capture cycle.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic         s0_valid = 1'b0;
    logic         s0_inv = 1'b0;
    logic         s0_ready = 1'b1;
    logic [127:0] s0_block = '0;
    logic         rst0_n = 1'b0;
    logic         rstb_n = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_run_flags(input int it, input bit inv);
        logic [3:0] f;
        if (it == 0)       f = 4'b1111;
        else if (it == NR) f = inv ? 4'b0110 : 4'b0111;
        else if (inv)      f = (it == 1) ? 4'b0001 : 4'b0000;
        else               f = 4'b0101;
        return {f, inv};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 15;

        logic         b_valid = 1'b0;
        logic         b_inv = 1'b0;
        logic [127:0] b_block = '0;
        logic         v_valid, v_inv, v_ready, v_rst_n;
        logic [127:0] v_block;
        logic         out_ready_in, out_valid, ld, rkb, s1, s2, einv, busy;
        logic [127:0] out_block, ele_s, ele_s_in;
        logic [3:0]   rk;

        assign v_valid  = (g == 0) ? s0_valid : b_valid;
        assign v_inv    = (g == 0) ? s0_inv   : b_inv;
        assign v_block  = (g == 0) ? s0_block : b_block;
        assign v_ready  = (g == 0) ? s0_ready : 1'b1;
        assign v_rst_n  = (g == 0) ? rst0_n   : rstb_n;
        assign ele_s_in = ele_s ^ {96'h0, cyc};

        aes_round_ctrl #(.ITER_LAT(L), .NR(NR)) u_dut (
            .clk                  (clk),
            .rst_n                (v_rst_n),
            .in_valid             (v_valid),
            .out_ready_in         (out_ready_in),
            .in_inv               (v_inv),
            .in_block             (v_block),
            .out_valid            (out_valid),
            .in_out_ready         (v_ready),
            .out_block            (out_block),
            .out_ele_load         (ld),
            .out_ele_rk_bypass    (rkb),
            .out_ele_smc_1_bypass (s1),
            .out_ele_smc_2_bypass (s2),
            .out_ele_inv          (einv),
            .out_ele_s            (ele_s),
            .in_ele_s             (ele_s_in),
            .out_rk_idx           (rk),
            .out_busy             (busy)
        );

        logic [127:0] exp_q[$];
        int           phase = 0;
        int           k = 0;
        int           n_done = 0;
        int unsigned  acc = 0;
        bit           m_inv = 0;
        bit           first = 0;
        logic [127:0] m_blk = '0;
        logic [127:0] exp_blk = '0;

        // Reference model, evaluated mid-cycle.
        always @(negedge clk) begin
            if (!v_rst_n) begin
                phase = 0;
                exp_q.delete();
            end else begin
                case (phase)
                    0: begin
                        chk($sformatf("i%0d idle_ready", g), out_ready_in, 1);
                        chk($sformatf("i%0d idle_busy", g), busy, 0);
                        chk($sformatf("i%0d idle_valid", g), out_valid, 0);
                        chk($sformatf("i%0d idle_flags", g), {ld, rkb, s1, s2, einv}, 5'b11000);
                        if (v_valid) begin
                            acc   = cyc;
                            m_blk = v_block;
                            m_inv = v_inv;
                            exp_q.push_back(m_blk ^ {96'h0, 32'(acc + (NR + 1) * L)});
                            k     = 0;
                            phase = 1;
                        end
                    end
                    1: begin
                        chk($sformatf("i%0d run_flags k=%0d", g, k), {ld, rkb, s1, s2, einv},
                            exp_run_flags(k / L, m_inv));
                        chk($sformatf("i%0d run_rk k=%0d", g, k), rk,
                            m_inv ? (NR - k / L) : (k / L));
                        chk($sformatf("i%0d run_ctl", g), {out_ready_in, busy, out_valid}, 3'b010);
                        chk($sformatf("i%0d run_ele_s", g), ele_s, m_blk);
                        k++;
                        if (k == (NR + 1) * L) begin
                            phase = 2;
                            first = 1;
                        end
                    end
                    default: begin
                        if (first) begin
                            first = 0;
                            n_done++;
                            chk($sformatf("i%0d latency", g), cyc - acc, (NR + 1) * L + 1);
                            chk($sformatf("i%0d sb_depth", g), exp_q.size(), 1);
                            exp_blk = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                        end
                        chk($sformatf("i%0d done_valid", g), out_valid, 1);
                        chk($sformatf("i%0d out_block", g), out_block, exp_blk);
                        chk($sformatf("i%0d done_ctl", g), {out_ready_in, busy}, 2'b01);
                        chk($sformatf("i%0d done_flags", g), {ld, rkb, s1, s2, einv}, 5'b11000);
                        if (v_ready) phase = 0;
                    end
                endcase
            end
        end

        if (g != 0) begin : g_b2b
            // Back-to-back requests with inputs churning every cycle.
            initial begin
                wait (rstb_n);
                #1;
                b_valid = 1'b1;
                for (int i = 0; i < 800; i++) begin
                    @(posedge clk);
                    #1;
                    b_block = {$urandom, $urandom, $urandom, $urandom};
                    b_inv   = 1'($urandom_range(0, 1));
                    if (n_done >= 3) break;
                end
                chk($sformatf("i%0d b2b_blocks", g), (n_done >= 3), 1);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " valid"}, g_inst[0].out_valid, 0);
        chk({tag, " block"}, g_inst[0].out_block, 0);
        chk({tag, " ele_s"}, g_inst[0].ele_s, 0);
        chk({tag, " rk"}, g_inst[0].rk, 0);
        chk({tag, " flags"}, {g_inst[0].ld, g_inst[0].rkb, g_inst[0].s1, g_inst[0].s2,
                              g_inst[0].einv}, 5'b11000);
        chk({tag, " ready_busy"}, {g_inst[0].out_ready_in, g_inst[0].busy}, 2'b10);
    endtask

    task automatic send0(input logic [127:0] blk, input logic inv);
        s0_block = blk;
        s0_inv   = inv;
        s0_valid = 1'b1;
        @(posedge clk);
        #1;
        s0_valid = 1'b0;
    endtask

    task automatic wait_valid0(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (g_inst[0].out_valid) return;
        end
        chk("valid_timeout", g_inst[0].out_valid, 1);
    endtask

    initial begin
        #2;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rstb_n = 1'b1;

        // Encrypt, accepted on the first edge after reset release.
        send0(128'h00112233445566778899aabbccddeeff, 1'b0);
        wait_valid0(100);
        @(posedge clk);
        #1;

        // Decrypt: key index walks NR down to 0.
        send0(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        wait_valid0(100);
        @(posedge clk);
        #1;

        // Back-pressure with a competing request held during DONE.
        s0_ready = 1'b0;
        send0(128'h0123456789abcdeffedcba9876543210, 1'b1);
        wait_valid0(100);
        s0_block = 128'hdeadbeef_00000000_cafef00d_12345678;
        s0_inv   = 1'b0;
        s0_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_ready_low", g_inst[0].out_ready_in, 0);
        s0_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after_consume", g_inst[0].out_ready_in, 1);
        @(posedge clk);
        #1;
        s0_valid = 1'b0;
        chk("bp_accepted", g_inst[0].busy, 1);
        wait_valid0(100);
        @(posedge clk);
        #1;

        // Reset in the middle of iteration 5, cycle 2.
        send0(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        repeat (22) @(posedge clk);
        #2;
        chk("rk_at_it5", g_inst[0].rk, 5);
        rst0_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        send0(128'h00112233445566778899aabbccddeeff, 1'b0);
        wait_valid0(100);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            if (g_inst[1].n_done >= 3 && g_inst[2].n_done >= 3) break;
            @(posedge clk);
        end
        chk("b2b_all_done", (g_inst[1].n_done >= 3 && g_inst[2].n_done >= 3), 1);
        #20;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
